// File: rtl/iob_msg_rx_if.sv
// Bundle of the UART-side and consumer-side signals of the receive message assembler.
// The master modport is the environment (UART + consumer); the slave modport is the assembler.
interface iob_msg_rx_if;
  logic [0:7]  uart_data;
  logic        uart_ready;
  logic        uart_busy;
  logic        reset;
  logic        cmd_ready;
  logic        busy;
  logic [0:7]  cmd;
  logic [0:7]  a1;
  logic [0:15] a2;
  logic [0:15] a3;
  logic        err;
  logic        ovf;

  modport master (
    output uart_data, uart_ready, uart_busy, reset,
    input  cmd_ready, busy, cmd, a1, a2, a3, err, ovf
  );

  modport slave (
    input  uart_data, uart_ready, uart_busy, reset,
    output cmd_ready, busy, cmd, a1, a2, a3, err, ovf
  );
endinterface

// File: rtl/iob_msg_rx.sv
// Receive-side message assembler: synchronises the UART strobes into clk_sys, captures a
// command byte plus up to five argument bytes, and holds the message until the consumer clears it.
module iob_msg_rx #(
  parameter int unsigned TIMEOUT_CLK = 50000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  iob_msg_rx_if.slave   bus
);

  localparam int unsigned CW = $clog2(TIMEOUT_CLK + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CLK);

  typedef enum logic [1:0] {
    IDLE,
    ARGS,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [SYNC_STAGES-1:0] rdy_sync_q, rdy_sync_d;
  logic [SYNC_STAGES-1:0] bsy_sync_q, bsy_sync_d;
  logic              rdy_prev_q, rdy_prev_d;
  logic [0:7]        cmd_q, cmd_d;
  logic [0:7]        a1_q, a1_d;
  logic [0:15]       a2_q, a2_d;
  logic [0:15]       a3_q, a3_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [CW-1:0]     tmo_q, tmo_d;

  logic              rdy_s;
  logic              bsy_s;
  logic              byte_ev;
  logic [2:0]        n_args;
  logic [2:0]        a2_start;
  logic [2:0]        a3_start;

  // Argument byte count carried by a command: a1 is one byte, a2 and a3 two bytes each.
  function automatic logic [2:0] arg_count(input logic [0:7] c);
    return {2'b00, c[1]} + {1'b0, c[2], 1'b0} + {1'b0, c[3], 1'b0};
  endfunction

  always_comb begin
    rdy_sync_d    = rdy_sync_q;
    bsy_sync_d    = bsy_sync_q;
    rdy_sync_d[0] = bus.uart_ready;
    bsy_sync_d[0] = bus.uart_busy;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      rdy_sync_d[i] = rdy_sync_q[i-1];
      bsy_sync_d[i] = bsy_sync_q[i-1];
    end
  end

  assign rdy_s      = rdy_sync_q[SYNC_STAGES-1];
  assign bsy_s      = bsy_sync_q[SYNC_STAGES-1];
  assign rdy_prev_d = rdy_s;
  assign byte_ev    = rdy_s & ~rdy_prev_q;

  assign n_args   = arg_count(cmd_q);
  assign a2_start = {2'b00, cmd_q[1]};
  assign a3_start = a2_start + {1'b0, cmd_q[2], 1'b0};

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    a1_d        = a1_q;
    a2_d        = a2_q;
    a3_d        = a3_q;
    cmd_ready_d = cmd_ready_q;
    busy_d      = busy_q;
    err_d       = 1'b0;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;

    // Consumer clear takes priority over any byte seen in the same cycle, in every state.
    if (bus.reset) begin
      state_d     = IDLE;
      cmd_ready_d = 1'b0;
      busy_d      = 1'b0;
      ovf_d       = 1'b0;
      cnt_d       = '0;
      tmo_d       = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (byte_ev) begin
            cmd_d       = bus.uart_data;
            a1_d        = '0;
            a2_d        = '0;
            a3_d        = '0;
            cmd_ready_d = 1'b1;
            cnt_d       = '0;
            tmo_d       = '0;
            if (arg_count(bus.uart_data) == 3'd0) begin
              state_d = DONE;
              busy_d  = 1'b0;
            end else begin
              state_d = ARGS;
              busy_d  = 1'b1;
            end
          end
        end

        ARGS: begin
          if (byte_ev) begin
            // Slot is chosen from the byte index and the presence bits; absent slots are skipped.
            if (cmd_q[1] && cnt_q == 3'd0) begin
              a1_d = bus.uart_data;
            end else if (cmd_q[2] && cnt_q == a2_start) begin
              a2_d[0:7] = bus.uart_data;
            end else if (cmd_q[2] && cnt_q == a2_start + 3'd1) begin
              a2_d[8:15] = bus.uart_data;
            end else if (cnt_q == a3_start) begin
              a3_d[0:7] = bus.uart_data;
            end else begin
              a3_d[8:15] = bus.uart_data;
            end
            cnt_d = cnt_q + 3'd1;
            tmo_d = '0;
            if (cnt_q + 3'd1 == n_args) begin
              state_d = DONE;
              busy_d  = 1'b0;
            end
          end else if (bsy_s) begin
            tmo_d = '0;
          end else if (tmo_q == TMAX) begin
            state_d     = IDLE;
            err_d       = 1'b1;
            cmd_ready_d = 1'b0;
            busy_d      = 1'b0;
            cmd_d       = '0;
            a1_d        = '0;
            a2_d        = '0;
            a3_d        = '0;
            cnt_d       = '0;
            tmo_d       = '0;
          end else begin
            tmo_d = tmo_q + CW'(1);
          end
        end

        DONE: begin
          if (byte_ev) begin
            ovf_d = 1'b1;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rdy_sync_q  <= '0;
      bsy_sync_q  <= '0;
      rdy_prev_q  <= 1'b0;
      cmd_q       <= '0;
      a1_q        <= '0;
      a2_q        <= '0;
      a3_q        <= '0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      rdy_sync_q  <= rdy_sync_d;
      bsy_sync_q  <= bsy_sync_d;
      rdy_prev_q  <= rdy_prev_d;
      cmd_q       <= cmd_d;
      a1_q        <= a1_d;
      a2_q        <= a2_d;
      a3_q        <= a3_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.busy      = busy_q;
  assign bus.cmd       = cmd_q;
  assign bus.a1        = a1_q;
  assign bus.a2        = a2_q;
  assign bus.a3        = a3_q;
  assign bus.err       = err_q;
  assign bus.ovf       = ovf_q;

endmodule
